// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multi-cycle MIPS main control: opcode values,
// 4-bit state encodings, ALU operation codes and datapath mux select codes.
// Used by the control FSM, its opcode decoder, the ALU control and benches.
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_LWC1  = 6'b110001;

   // Control states; the encoding is visible on the debug state port.
   typedef enum logic [3:0] {
      S_RESET   = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_MEMADR  = 4'd3,
      S_MEMRD   = 4'd4,
      S_MEMWB   = 4'd5,
      S_MEMWR   = 4'd6,
      S_EXEC    = 4'd7,
      S_ALUWB   = 4'd8,
      S_BRANCH  = 4'd9,
      S_IEXEC   = 4'd10,
      S_IWB     = 4'd11,
      S_JUMP    = 4'd12,
      S_ILLEGAL = 4'd13
   } state_t;

   // ALU operation codes (zero-extended to ALUOP_W at the top level)
   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_FUNCT = 3'b010;
   localparam logic [2:0] ALU_AND   = 3'b011;
   localparam logic [2:0] ALU_SLT   = 3'b100;
   localparam logic [2:0] ALU_OR    = 3'b101;

   // ALU operand B select
   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   // PC source select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // True for the opcodes that take the memory-address path.
   function automatic logic is_mem_op(input logic [5:0] opc);
      return (opc == OP_LW) || (opc == OP_LWC1) || (opc == OP_SW);
   endfunction

endpackage

// File: rtl/unidad_control_decode.sv
// -----------------------------------------------------------------------------
// unidad_control_decode
// Combinational opcode decoder used in DECODE: picks the state that follows
// DECODE and the ALU operation an I-type instruction will use in IEXEC.
// Ports:
//   i_opcode      in   6  IR[31:26]
//   o_next_state  out  4  state entered after DECODE (state_t encoding)
//   o_op_q        out  3  ALU op for IEXEC (add for anything not an ALU immediate)
// -----------------------------------------------------------------------------
module unidad_control_decode
   import mips_ctrl_pkg::*;
#(
   parameter bit ENABLE_JUMP = 1'b1
)(
   input  logic [5:0] i_opcode,
   output logic [3:0] o_next_state,
   output logic [2:0] o_op_q
);

   always_comb begin
      o_next_state = S_ILLEGAL;
      o_op_q       = ALU_ADD;
      case (i_opcode)
         OP_RTYPE: o_next_state = S_EXEC;
         OP_BEQ:   o_next_state = S_BRANCH;
         OP_ADDI: begin
            o_next_state = S_IEXEC;
            o_op_q       = ALU_ADD;
         end
         OP_SLTI: begin
            o_next_state = S_IEXEC;
            o_op_q       = ALU_SLT;
         end
         OP_ANDI: begin
            o_next_state = S_IEXEC;
            o_op_q       = ALU_AND;
         end
         OP_ORI: begin
            o_next_state = S_IEXEC;
            o_op_q       = ALU_OR;
         end
         OP_J: begin
            // With jumps disabled J falls through to the illegal trap.
            if (ENABLE_JUMP) o_next_state = S_JUMP;
         end
         default: begin
            if (is_mem_op(i_opcode)) o_next_state = S_MEMADR;
         end
      endcase
   end

endmodule

// File: rtl/unidad_control_multiciclo.sv
// -----------------------------------------------------------------------------
// unidad_control_multiciclo
// Multi-cycle MIPS main control FSM. Sequences FETCH/DECODE/EXEC/MEM/WB for
// each instruction and drives the shared datapath enables. Memory states
// stall on the mem_ready handshake.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RESET    | idle after reset, all enables off
// FETCH    | read instruction at PC, PC+4; PC/IR load when memory is ready
// DECODE   | read registers, compute branch target, capture op_q
// MEMADR   | compute A + signext(imm) for load/store
// MEMRD    | read data memory at ALUOut
// MEMWB    | write MDR to rt
// MEMWR    | write B to memory at ALUOut
// EXEC     | R-type ALU operation (funct)
// ALUWB    | write ALUOut to rd
// BRANCH   | BEQ compare, PC <= ALUOut on zero
// IEXEC    | ALU immediate operation using op_q
// IWB      | write ALUOut to rt
// JUMP     | PC <= jump target
// ILLEGAL  | unknown opcode trapped; held until reset
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   opcode           IR[31:26], stable from DECODE to instruction end
//   mem_ready        memory access completes this cycle
//   pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
//   pc_source        datapath controls
//   state            current state (debug)
//   illegal_op       sticky illegal-opcode flag
// -----------------------------------------------------------------------------
module unidad_control_multiciclo
   import mips_ctrl_pkg::*;
#(
   parameter int ALUOP_W       = 3,
   parameter bit MEM_HANDSHAKE = 1'b1,
   parameter bit ENABLE_JUMP   = 1'b1
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         opcode,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               pc_write_cond,
   output logic               i_or_d,
   output logic               mem_read,
   output logic               mem_write,
   output logic               ir_write,
   output logic               mem_to_reg,
   output logic               reg_dst,
   output logic               reg_write,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [ALUOP_W-1:0] alu_op,
   output logic [1:0]         pc_source,
   output logic [3:0]         state,
   output logic               illegal_op
);

   state_t     r_state;
   logic [2:0] r_op_q;
   logic       r_illegal;

   logic       w_mem_ready;
   logic [3:0] w_dec_state;
   logic [2:0] w_dec_op;
   logic [2:0] w_alu_op;

   assign w_mem_ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

   unidad_control_decode #(
      .ENABLE_JUMP (ENABLE_JUMP)
   ) u_decode (
      .i_opcode     (opcode),
      .o_next_state (w_dec_state),
      .o_op_q       (w_dec_op)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_RESET;
         r_op_q    <= ALU_ADD;
         r_illegal <= 1'b0;
      end else begin
         case (r_state)
            S_RESET:  r_state <= S_FETCH;
            S_FETCH: begin
               if (w_mem_ready) r_state <= S_DECODE;
            end
            S_DECODE: begin
               r_state <= state_t'(w_dec_state);
               r_op_q  <= w_dec_op;
               if (state_t'(w_dec_state) == S_ILLEGAL) r_illegal <= 1'b1;
            end
            S_MEMADR: r_state <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
               if (w_mem_ready) r_state <= S_MEMWB;
            end
            S_MEMWR: begin
               if (w_mem_ready) r_state <= S_FETCH;
            end
            S_EXEC:   r_state <= S_ALUWB;
            S_IEXEC:  r_state <= S_IWB;
            S_ALUWB,
            S_IWB,
            S_MEMWB,
            S_BRANCH,
            S_JUMP:   r_state <= S_FETCH;
            S_ILLEGAL: r_state <= S_ILLEGAL;
            default:  r_state <= S_FETCH;
         endcase
      end
   end

   // Enables are decoded from the state register so reset clears them
   // asynchronously. PC/IR load in FETCH follows mem_ready directly, so the
   // write lands on the single cycle in which the fetch completes.
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_REG;
      pc_source     = PCSRC_ALU;
      w_alu_op      = ALU_ADD;
      case (r_state)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_write  = w_mem_ready;
            pc_write  = w_mem_ready;
         end
         S_DECODE: alu_src_b = SRCB_IMM_SH;
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         S_MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
         end
         S_MEMWR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            w_alu_op  = ALU_FUNCT;
         end
         S_ALUWB: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            w_alu_op      = ALU_SUB;
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_ALUOUT;
         end
         S_IEXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            w_alu_op  = r_op_q;
         end
         S_IWB:    reg_write = 1'b1;
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = PCSRC_JUMP;
         end
         default: ;
      endcase
   end

   always_comb begin
      alu_op        = '0;
      alu_op[2:0]   = w_alu_op;
   end

   assign state      = r_state;
   assign illegal_op = r_illegal;

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
module tb_unidad_control_multiciclo;
   import mips_ctrl_pkg::*;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [3:0] alu_op;
      logic [1:0] pc_source;
      logic [3:0] state;
      logic       illegal_op;
   } snap_t;

   typedef struct packed {
      logic  sel;
      snap_t s;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n, rst2_n, mem_ready;
   logic [5:0] opcode;
   logic       active;
   int         checks = 0;
   int         failures = 0;
   exp_t       exp_q[$];

   always #5 clk = ~clk;

   logic       d1_pcw, d1_pcwc, d1_iod, d1_mr, d1_mw, d1_irw, d1_m2r, d1_rdst, d1_rw, d1_sa;
   logic [1:0] d1_sb, d1_ps;
   logic [2:0] d1_aop;
   logic [3:0] d1_st;
   logic       d1_ill;
   logic       d2_pcw, d2_pcwc, d2_iod, d2_mr, d2_mw, d2_irw, d2_m2r, d2_rdst, d2_rw, d2_sa;
   logic [1:0] d2_sb, d2_ps;
   logic [3:0] d2_aop;
   logic [3:0] d2_st;
   logic       d2_ill;
   snap_t      a1, a2;

   unidad_control_multiciclo #(.ALUOP_W(3), .MEM_HANDSHAKE(1'b1), .ENABLE_JUMP(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(d1_pcw), .pc_write_cond(d1_pcwc), .i_or_d(d1_iod), .mem_read(d1_mr),
      .mem_write(d1_mw), .ir_write(d1_irw), .mem_to_reg(d1_m2r), .reg_dst(d1_rdst),
      .reg_write(d1_rw), .alu_src_a(d1_sa), .alu_src_b(d1_sb), .alu_op(d1_aop),
      .pc_source(d1_ps), .state(d1_st), .illegal_op(d1_ill));

   unidad_control_multiciclo #(.ALUOP_W(4), .MEM_HANDSHAKE(1'b0), .ENABLE_JUMP(1'b0)) dut2 (
      .clk(clk), .rst_n(rst2_n), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(d2_pcw), .pc_write_cond(d2_pcwc), .i_or_d(d2_iod), .mem_read(d2_mr),
      .mem_write(d2_mw), .ir_write(d2_irw), .mem_to_reg(d2_m2r), .reg_dst(d2_rdst),
      .reg_write(d2_rw), .alu_src_a(d2_sa), .alu_src_b(d2_sb), .alu_op(d2_aop),
      .pc_source(d2_ps), .state(d2_st), .illegal_op(d2_ill));

   assign a1 = {d1_pcw, d1_pcwc, d1_iod, d1_mr, d1_mw, d1_irw, d1_m2r, d1_rdst, d1_rw, d1_sa,
                d1_sb, 1'b0, d1_aop, d1_ps, d1_st, d1_ill};
   assign a2 = {d2_pcw, d2_pcwc, d2_iod, d2_mr, d2_mw, d2_irw, d2_m2r, d2_rdst, d2_rw, d2_sa,
                d2_sb, d2_aop, d2_ps, d2_st, d2_ill};

   // Monitor: one expected snapshot per cycle, compared mid-cycle.
   exp_t  m_e;
   snap_t m_a;
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         m_e = exp_q.pop_front();
         m_a = m_e.sel ? a2 : a1;
         checks++;
         if (m_a !== m_e.s) begin
            failures++;
            $display("FAIL outputs dut%0d t=%0t got=%h (state %0d) exp=%h (state %0d)",
                     32'(m_e.sel) + 1, $time, m_a, m_a.state, m_e.s, m_e.s.state);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
      end
   endtask

   function automatic bit rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [5:0] jnk();
      return 6'($urandom);
   endfunction

   // Expected outputs for one cycle spent in a given control step.
   function automatic snap_t step_exp(input state_t st, input bit done, input logic [2:0] iop);
      snap_t s;
      s = '0;
      s.state = st;
      case (st)
         S_FETCH:   begin s.mem_read = 1'b1; s.alu_src_b = 2'b01; s.ir_write = done; s.pc_write = done; end
         S_DECODE:  s.alu_src_b = 2'b11;
         S_MEMADR:  begin s.alu_src_a = 1'b1; s.alu_src_b = 2'b10; end
         S_MEMRD:   begin s.mem_read = 1'b1; s.i_or_d = 1'b1; end
         S_MEMWB:   begin s.mem_to_reg = 1'b1; s.reg_write = 1'b1; end
         S_MEMWR:   begin s.mem_write = 1'b1; s.i_or_d = 1'b1; end
         S_EXEC:    begin s.alu_src_a = 1'b1; s.alu_op = 4'b0010; end
         S_ALUWB:   begin s.reg_dst = 1'b1; s.reg_write = 1'b1; end
         S_BRANCH:  begin s.alu_src_a = 1'b1; s.alu_op = 4'b0001; s.pc_write_cond = 1'b1; s.pc_source = 2'b01; end
         S_IEXEC:   begin s.alu_src_a = 1'b1; s.alu_src_b = 2'b10; s.alu_op = {1'b0, iop}; end
         S_IWB:     s.reg_write = 1'b1;
         S_JUMP:    begin s.pc_write = 1'b1; s.pc_source = 2'b10; end
         S_ILLEGAL: s.illegal_op = 1'b1;
         default: ;
      endcase
      return s;
   endfunction

   function automatic logic [2:0] imm_alu(input logic [5:0] opc);
      if (opc == 6'b001010) return 3'b100;
      if (opc == 6'b001100) return 3'b011;
      if (opc == 6'b001101) return 3'b101;
      return 3'b000;
   endfunction

   task automatic cyc(input bit mr, input logic [5:0] opc, input snap_t e);
      exp_t x;
      mem_ready = mr;
      opcode    = opc;
      x.sel     = active;
      x.s       = e;
      exp_q.push_back(x);
      @(posedge clk); #1;
   endtask

   task automatic do_reset(input int hold);
      if (active == 1'b0) rst_n = 1'b0; else rst2_n = 1'b0;
      for (int i = 0; i < hold; i++) cyc(rb(), jnk(), '0);
      if (active == 1'b0) rst_n = 1'b1; else rst2_n = 1'b1;
      cyc(rb(), jnk(), '0);
   endtask

   // Reference model: an instruction is a fetch, a decode, then a short
   // list of class-specific steps; memory steps repeat once per stall cycle.
   task automatic run_instr(input logic [5:0] opc, input int fstall, input int mstall, input bit abort);
      bit         hs;
      bit         ej;
      bit         trap;
      logic [2:0] iop;
      state_t     post[$];
      hs   = (active == 1'b0);
      ej   = (active == 1'b0);
      trap = 1'b0;
      iop  = imm_alu(opc);
      if (hs) for (int i = 0; i < fstall; i++) cyc(1'b0, jnk(), step_exp(S_FETCH, 1'b0, 3'd0));
      cyc(hs ? 1'b1 : rb(), jnk(), step_exp(S_FETCH, 1'b1, 3'd0));
      cyc(rb(), opc, step_exp(S_DECODE, 1'b0, 3'd0));
      case (opc)
         6'b000000: begin post.push_back(S_EXEC); post.push_back(S_ALUWB); end
         6'b100011, 6'b110001: begin post.push_back(S_MEMADR); post.push_back(S_MEMRD); post.push_back(S_MEMWB); end
         6'b101011: begin post.push_back(S_MEMADR); post.push_back(S_MEMWR); end
         6'b000100: post.push_back(S_BRANCH);
         6'b001000, 6'b001010, 6'b001100, 6'b001101: begin post.push_back(S_IEXEC); post.push_back(S_IWB); end
         6'b000010: if (ej) post.push_back(S_JUMP); else trap = 1'b1;
         default: trap = 1'b1;
      endcase
      if (trap) for (int i = 0; i < 3; i++) post.push_back(S_ILLEGAL);
      foreach (post[k]) begin
         if ((post[k] == S_MEMRD || post[k] == S_MEMWR) && hs) begin
            for (int i = 0; i < mstall; i++) begin
               if (abort && post[k] == S_MEMWR) begin
                  mem_ready = 1'b0;
                  opcode    = opc;
                  begin
                     exp_t x;
                     x.sel = active;
                     x.s   = step_exp(S_MEMWR, 1'b0, iop);
                     exp_q.push_back(x);
                  end
                  @(negedge clk); #1;
                  rst_n = 1'b0;
                  #1;
                  chk("abort_mem_write", 32'(d1_mw), 32'd0);
                  chk("abort_i_or_d", 32'(d1_iod), 32'd0);
                  chk("abort_state", 32'(d1_st), 32'(S_RESET));
                  @(posedge clk); #1;
                  do_reset(1);
                  return;
               end
               cyc(1'b0, opc, step_exp(post[k], 1'b0, iop));
            end
            cyc(1'b1, opc, step_exp(post[k], 1'b0, iop));
         end else begin
            cyc(rb(), opc, step_exp(post[k], 1'b0, iop));
         end
      end
      if (trap) do_reset(2);
   endtask

   logic [5:0] legal_ops[10] = '{6'b000000, 6'b100011, 6'b110001, 6'b101011, 6'b000100,
                                 6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b000010};
   logic [5:0] bad_ops[4]    = '{6'b111111, 6'b000001, 6'b100000, 6'b001111};

   initial begin
      logic [5:0] op;
      rst_n = 1'b0; rst2_n = 1'b0; mem_ready = 1'b0; opcode = 6'd0; active = 1'b0;
      @(posedge clk); #1;
      do_reset(2);
      run_instr(6'b000000, 0, 0, 1'b0);   // R-type
      run_instr(6'b100011, 0, 2, 1'b0);   // LW, two read stalls
      run_instr(6'b001101, 1, 0, 1'b0);   // ORI
      run_instr(6'b001010, 0, 0, 1'b0);   // SLTI
      run_instr(6'b000100, 0, 0, 1'b0);   // BEQ
      run_instr(6'b000010, 0, 0, 1'b0);   // J enabled
      run_instr(6'b101011, 1, 2, 1'b1);   // SW aborted by reset in MEMWR
      run_instr(6'b001100, 0, 0, 1'b0);   // ANDI after reset
      run_instr(6'b111111, 0, 0, 1'b0);   // illegal trap then reset
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 14) == 0) op = bad_ops[$urandom_range(0, 3)];
         else op = legal_ops[$urandom_range(0, 9)];
         run_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0);
      end
      rst_n  = 1'b0;
      active = 1'b1;
      do_reset(1);
      run_instr(6'b100011, 2, 2, 1'b0);   // stalls requested but handshake ignored
      for (int n = 0; n < 10; n++) run_instr(legal_ops[$urandom_range(0, 8)], 1, 1, 1'b0);
      run_instr(6'b000010, 0, 0, 1'b0);   // J disabled -> trap
      run_instr(6'b101011, 0, 0, 1'b0);
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
